count_watch: RTL and testbench
==============================

COUNT_WATCH -- requirements
Module: count_watch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter STALL_LIM, default 16, consecutive unchanged samples that raise a STALL event (2..255).
REQ-003 The block SHALL have port clk, input, 1, single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous and active-high.
REQ-005 The block SHALL have port value, input, 8, count output of the upstream counter, sampled every cycle.
REQ-006 The block SHALL have port threshold, input, 8, crossing level, sampled every cycle.
REQ-007 The block SHALL have port evt_valid, output, 1, FIFO head holds an event.
REQ-008 The block SHALL have port evt_ready, input, 1, consumer accepts the head event.
REQ-009 The block SHALL have port evt_code, output, 2, head event code: 00 WRAP, 01 DROP, 10 CROSS, 11 STALL.
REQ-010 The block SHALL have port evt_stamp, output, 16, timestamp of the head event.
REQ-011 The block SHALL have port overflow, output, 1, sticky flag for an event lost to a full FIFO.

Function
REQ-012 The block SHALL keep a free-running 16-bit timestamp: 0 in the first cycle after reset deasserts, +1 per cycle, FFFF wraps to 0000.
REQ-013 The block SHALL register the previous sample prev and a prev_ok flag; prev_ok is 0 after reset and 1 from the second sample, and no event is detected while prev_ok=0.
REQ-014 WRAP SHALL be detected when prev=FF and value=00.
REQ-015 DROP SHALL be detected when value<prev and not WRAP (upstream reset or discontinuity).
REQ-016 CROSS SHALL be detected when prev<threshold and value>=threshold.
REQ-017 The block SHALL count consecutive cycles with value==prev, saturating; STALL fires exactly once, on the sample where the count reaches STALL_LIM, and re-arms only after value changes.
REQ-018 WRAP, DROP, CROSS and STALL are mutually exclusive by definition; at most one event SHALL be pushed per cycle.
REQ-019 A detected event SHALL be pushed with the current cycle's timestamp; if the FIFO was empty, evt_valid SHALL rise on the next cycle (latency 1).
REQ-020 Transfer SHALL occur when evt_valid and evt_ready are both high; the head pops at that edge.
REQ-021 evt_code and evt_stamp SHALL be stable while evt_valid=1 and evt_ready=0, and SHALL be 0 when empty.
REQ-022 Push when full with no pop SHALL drop the new event and set overflow=1 until reset.
REQ-023 Push and pop in the same cycle when full SHALL be accepted with no overflow; when empty, push SHALL be accepted and pop ignored.
REQ-024 Events SHALL leave in push order.

Reset
REQ-025 On reset=1 at an edge, outputs SHALL be evt_valid=0, evt_code=0, evt_stamp=0, overflow=0, and the FIFO SHALL be empty, timestamp 0, prev_ok=0, stall count 0.
REQ-026 Reset asserted mid-operation SHALL discard all queued events at that edge, regardless of evt_ready.

Structure
REQ-027 Package count_watch_pkg SHALL hold the event-code enum, the 16-bit stamp width and the {code,stamp} entry typedef.
REQ-028 The FIFO SHALL be a sub-module count_watch_fifo (DEPTH, entry type) with valid/ready output and a full flag.

Verification
REQ-029 Upstream counter free-running 00..FF, evt_ready=1 -> one WRAP per 256 cycles, stamps spaced by 256.
REQ-030 value 05,06,07 then 00 (upstream reset) -> exactly one DROP, stamp equal to the cycle of the 00 sample.
REQ-031 threshold=80, value 7E,7F,80,81 -> one CROSS at the 80 sample; value at 90 with threshold raised to A0 then 90,A0 -> CROSS at A0.
REQ-032 value held at 33 for 40 cycles, STALL_LIM=16 -> one STALL, at the 16th equal sample; then 34,34.. for 16 samples -> second STALL.
REQ-033 evt_ready=0, 5 WRAPs with DEPTH=4 -> 4 entries retained in order, overflow=1; then evt_ready=1 -> 4 transfers, evt_valid=0, overflow stays 1.
REQ-034 reset pulsed with 3 queued events -> evt_valid=0 next cycle, overflow=0, first post-reset sample raises no event.

Source files
------------

// File: rtl/count_watch_pkg.sv
// count_watch_pkg: shared types and widths for the count_watch block.
//   evt_code_t  - event code carried in each FIFO entry
//   evt_entry_t - {code, stamp} payload pushed into the event FIFO
package count_watch_pkg;

    localparam int unsigned VALUE_W = 8;
    localparam int unsigned STAMP_W = 16;
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [CODE_W-1:0] {
        EVT_WRAP  = 2'b00,
        EVT_DROP  = 2'b01,
        EVT_CROSS = 2'b10,
        EVT_STALL = 2'b11
    } evt_code_t;

    typedef struct packed {
        evt_code_t            code;
        logic [STAMP_W-1:0]   stamp;
    } evt_entry_t;

    localparam int unsigned ENTRY_W = $bits(evt_entry_t);

endpackage

// File: rtl/count_watch_fifo.sv
// count_watch_fifo: DEPTH-entry event queue with a valid/ready read side.
// The head entry and valid flag are registered; the head reads as zero when
// the queue is empty.
//   clk, reset         - clock, synchronous active-high reset
//   push, din          - write request and payload (dropped when full, no pop)
//   full               - registered full flag
//   out_valid          - head holds an entry
//   out_ready          - consumer accepts the head this cycle
//   dout               - head entry (zero when empty)
module count_watch_fifo
    import count_watch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = evt_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t din,
    output logic   full,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr_n;
    logic [AW-1:0]   wr_ptr_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic            pop_acc;
    logic            push_acc;
    entry_t          head_n;

    // Next-state pointers, occupancy and the head that will be visible after
    // this edge. A full queue still accepts a push when the head pops.
    always_comb begin
        pop_acc  = out_valid && out_ready;
        push_acc = push && (!full || pop_acc);
        rd_ptr_n = pop_acc  ? rd_ptr + AW'(1) : rd_ptr;
        wr_ptr_n = push_acc ? wr_ptr + AW'(1) : wr_ptr;
        count_n  = count + CW'(push_acc) - CW'(pop_acc);
        head_n   = '0;
        if (count_n != '0) begin
            // Write-through when the new entry lands in the head slot.
            if (push_acc && (wr_ptr == rd_ptr_n)) begin
                head_n = din;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    // Control state and registered head.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            count     <= count_n;
            full      <= (count_n == CW'(DEPTH));
            out_valid <= (count_n != '0);
            dout      <= head_n;
        end
    end

    // Storage array; no reset needed since pointers define what is live.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/count_watch.sv
// count_watch: watches an 8-bit upstream counter and queues timestamped
// WRAP / DROP / CROSS / STALL events for a valid/ready consumer.
//   clk, reset   - clock, synchronous active-high reset
//   value        - upstream count, sampled every cycle
//   threshold    - crossing level, sampled every cycle
//   evt_valid    - head event present
//   evt_ready    - consumer accepts head event
//   evt_code     - head event code (0 when empty)
//   evt_stamp    - head event timestamp (0 when empty)
//   overflow     - sticky: an event was lost to a full queue
module count_watch
    import count_watch_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned STALL_LIM = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    input  logic [VALUE_W-1:0] threshold,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CODE_W-1:0]  evt_code,
    output logic [STAMP_W-1:0] evt_stamp,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] LIM    = CNT_W'(STALL_LIM);
    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STALL_LIM - 1);

    logic [STAMP_W-1:0] stamp;
    logic [VALUE_W-1:0] prev;
    logic               prev_ok;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   stall_cnt_n;

    logic               same;
    logic               det_wrap;
    logic               det_drop;
    logic               det_cross;
    logic               det_stall;
    logic               push;
    evt_entry_t         entry;
    evt_entry_t         head;
    logic               full;

    // Event detection against the previous sample. stall_cnt holds the number
    // of equal samples seen before this one, so STALL fires when this sample
    // is the STALL_LIM-th equal one; saturating at LIM keeps it one-shot.
    always_comb begin
        same      = (value == prev);
        det_wrap  = prev_ok && (prev == {VALUE_W{1'b1}}) && (value == '0);
        det_drop  = prev_ok && (value < prev) && !det_wrap;
        det_cross = prev_ok && (prev < threshold) && (value >= threshold);
        det_stall = prev_ok && same && (stall_cnt == LIM_M1);

        push        = 1'b0;
        entry.code  = EVT_WRAP;
        entry.stamp = stamp;
        if (det_wrap) begin
            push       = 1'b1;
            entry.code = EVT_WRAP;
        end else if (det_drop) begin
            push       = 1'b1;
            entry.code = EVT_DROP;
        end else if (det_cross) begin
            push       = 1'b1;
            entry.code = EVT_CROSS;
        end else if (det_stall) begin
            push       = 1'b1;
            entry.code = EVT_STALL;
        end

        stall_cnt_n = '0;
        if (prev_ok && same) begin
            stall_cnt_n = (stall_cnt == LIM) ? stall_cnt : stall_cnt + CNT_W'(1);
        end
    end

    // Timestamp, sample history and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            stamp     <= '0;
            prev      <= '0;
            prev_ok   <= 1'b0;
            stall_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            stamp     <= stamp + STAMP_W'(1);
            prev      <= value;
            prev_ok   <= 1'b1;
            stall_cnt <= stall_cnt_n;
            if (push && full && !(evt_valid && evt_ready)) begin
                overflow <= 1'b1;
            end
        end
    end

    count_watch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (evt_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .din       (entry),
        .full      (full),
        .out_valid (evt_valid),
        .out_ready (evt_ready),
        .dout      (head)
    );

    assign evt_code  = head.code;
    assign evt_stamp = head.stamp;

endmodule

// File: tb/tb_count_watch.sv
// tb_count_watch: directed scenarios plus randomized traffic for count_watch,
// checked cycle by cycle against a queue-based reference model.
module tb_count_watch;
    import count_watch_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned STALL_LIM = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  value;
    logic [7:0]  threshold;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_code;
    logic [15:0] evt_stamp;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    count_watch #(
        .DEPTH     (DEPTH),
        .STALL_LIM (STALL_LIM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .threshold (threshold),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_stamp (evt_stamp),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_ts;
    logic [7:0]  m_prev;
    bit          m_prev_ok;
    int          m_run;
    bit          m_ovf;
    evt_entry_t  m_q[$];
    evt_entry_t  log_q[$];

    task automatic model_step();
        evt_entry_t e;
        bit         have;
        if (reset) begin
            m_ts = 16'd0; m_prev = 8'd0; m_prev_ok = 0; m_run = 0; m_ovf = 0;
            m_q.delete();
            return;
        end
        if (evt_ready && m_q.size() > 0) void'(m_q.pop_front());
        have = 0;
        e.stamp = m_ts;
        e.code  = EVT_WRAP;
        if (m_prev_ok) begin
            if (m_prev == 8'hFF && value == 8'h00) begin have = 1; e.code = EVT_WRAP; end
            else if (value < m_prev) begin have = 1; e.code = EVT_DROP; end
            else if (m_prev < threshold && value >= threshold) begin have = 1; e.code = EVT_CROSS; end
        end
        if (m_prev_ok && value == m_prev) begin
            m_run++;
            if (m_run == int'(STALL_LIM) && !have) begin have = 1; e.code = EVT_STALL; end
        end else begin
            m_run = 0;
        end
        if (have) begin
            if (m_q.size() < int'(DEPTH)) m_q.push_back(e);
            else m_ovf = 1;
        end
        m_prev = value;
        m_prev_ok = 1;
        m_ts = m_ts + 16'd1;
    endtask

    task automatic check_outputs();
        logic        exp_valid;
        logic [1:0]  exp_code;
        logic [15:0] exp_stamp;
        exp_valid = (m_q.size() > 0);
        exp_code  = exp_valid ? m_q[0].code : 2'd0;
        exp_stamp = exp_valid ? m_q[0].stamp : 16'd0;
        checks++;
        assert (evt_valid === exp_valid) else begin
            errors++; $error("FAIL evt_valid got %0b want %0b at %0t", evt_valid, exp_valid, $time);
        end
        checks++;
        assert (evt_code === exp_code) else begin
            errors++; $error("FAIL evt_code got %0d want %0d at %0t", evt_code, exp_code, $time);
        end
        checks++;
        assert (evt_stamp === exp_stamp) else begin
            errors++; $error("FAIL evt_stamp got %0h want %0h at %0t", evt_stamp, exp_stamp, $time);
        end
        checks++;
        assert (overflow === m_ovf) else begin
            errors++; $error("FAIL overflow got %0b want %0b at %0t", overflow, m_ovf, $time);
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    // One clock: drive, log any transfer, model the edge, check outputs.
    task automatic cyc(input logic [7:0] v, input logic [7:0] t, input logic r, input logic rs);
        value = v; threshold = t; evt_ready = r; reset = rs;
        #1;
        if (!rs && evt_valid && evt_ready)
            log_q.push_back(evt_entry_t'{code: evt_code_t'(evt_code), stamp: evt_stamp});
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic int count_code(input logic [1:0] c);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].code == c) n++;
        return n;
    endfunction

    function automatic int stamp_of(input logic [1:0] c, input int k);
        int n = 0;
        foreach (log_q[i]) begin
            if (log_q[i].code == c) begin
                if (n == k) return int'(log_q[i].stamp);
                n++;
            end
        end
        return -1;
    endfunction

    initial begin
        int          mark;
        logic [7:0]  cur;
        logic [7:0]  thr;
        int          hold;

        value = 8'd0; threshold = 8'd0; evt_ready = 1'b0; reset = 1'b1;
        m_ts = 16'd0; m_prev = 8'd0; m_prev_ok = 0; m_run = 0; m_ovf = 0;

        // Reset state
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);

        // Free-running counter: WRAP every 256 cycles
        log_q.delete();
        for (int i = 1; i <= 600; i++) cyc(8'(i), 8'h00, 1'b1, 1'b0);
        chk("wrap_count", count_code(EVT_WRAP), 2);
        chk("wrap_total", log_q.size(), 2);
        chk("wrap_first_stamp", stamp_of(EVT_WRAP, 0), 255);
        chk("wrap_spacing", stamp_of(EVT_WRAP, 1) - stamp_of(EVT_WRAP, 0), 256);

        // Upstream reset: 05,06,07,00 gives one DROP at the 00 sample
        cyc(8'h03, 8'h00, 1'b1, 1'b0);
        cyc(8'h04, 8'h00, 1'b1, 1'b0);
        log_q.delete();
        cyc(8'h05, 8'h00, 1'b1, 1'b0);
        cyc(8'h06, 8'h00, 1'b1, 1'b0);
        cyc(8'h07, 8'h00, 1'b1, 1'b0);
        mark = int'(m_ts);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) cyc(8'(i), 8'h00, 1'b1, 1'b0);
        chk("drop_count", count_code(EVT_DROP), 1);
        chk("drop_total", log_q.size(), 1);
        chk("drop_stamp", stamp_of(EVT_DROP, 0), mark);

        // Threshold crossings
        log_q.delete();
        cyc(8'h7E, 8'h80, 1'b1, 1'b0);
        cyc(8'h7F, 8'h80, 1'b1, 1'b0);
        mark = int'(m_ts);
        cyc(8'h80, 8'h80, 1'b1, 1'b0);
        cyc(8'h81, 8'h80, 1'b1, 1'b0);
        cyc(8'h90, 8'hA0, 1'b1, 1'b0);
        cyc(8'h90, 8'hA0, 1'b1, 1'b0);
        cyc(8'hA0, 8'hA0, 1'b1, 1'b0);
        cyc(8'hA1, 8'hA0, 1'b1, 1'b0);
        cyc(8'hA2, 8'hA0, 1'b1, 1'b0);
        chk("cross_count", count_code(EVT_CROSS), 2);
        chk("cross_total", log_q.size(), 2);
        chk("cross_first_stamp", stamp_of(EVT_CROSS, 0), mark);
        chk("cross_gap", stamp_of(EVT_CROSS, 1) - stamp_of(EVT_CROSS, 0), 4);

        // Stall: 33 held 40 cycles, then 34 held 17 samples
        log_q.delete();
        for (int i = 0; i < 40; i++) cyc(8'h33, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) cyc(8'h34, 8'h00, 1'b1, 1'b0);
        cyc(8'h35, 8'h00, 1'b1, 1'b0);
        cyc(8'h36, 8'h00, 1'b1, 1'b0);
        chk("stall_count", count_code(EVT_STALL), 2);
        chk("stall_drop_count", count_code(EVT_DROP), 1);
        chk("stall_first_offset", stamp_of(EVT_STALL, 0) - stamp_of(EVT_DROP, 0), 16);
        chk("stall_gap", stamp_of(EVT_STALL, 1) - stamp_of(EVT_STALL, 0), 40);

        // Overflow: 5 WRAPs with consumer stalled
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        log_q.delete();
        for (int i = 0; i <= 1280; i++) cyc(8'(i), 8'h00, 1'b0, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_full_valid", int'(evt_valid), 1);
        for (int i = 1281; i <= 1290; i++) cyc(8'(i), 8'h00, 1'b1, 1'b0);
        chk("ovf_drained", log_q.size(), 4);
        chk("ovf_wraps", count_code(EVT_WRAP), 4);
        for (int j = 0; j < 4; j++) chk("ovf_order", stamp_of(EVT_WRAP, j), 256 * (j + 1));
        chk("ovf_empty", int'(evt_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset with 3 queued events
        cyc(8'h05, 8'h00, 1'b0, 1'b0);
        cyc(8'h09, 8'h00, 1'b0, 1'b0);
        cyc(8'h04, 8'h00, 1'b0, 1'b0);
        cyc(8'h09, 8'h00, 1'b0, 1'b0);
        cyc(8'h03, 8'h00, 1'b0, 1'b0);
        chk("rst_queued_valid", int'(evt_valid), 1);
        cyc(8'h03, 8'h00, 1'b0, 1'b1);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        chk("rst_first_sample", int'(evt_valid), 0);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);

        // Randomized traffic
        cur = 8'h00; thr = 8'h40;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    hold = 1;
                2:       hold = $urandom_range(10, 20);
                3, 4, 5: begin cur = cur + 8'd1; hold = 1; end
                6:       begin cur = 8'($urandom); hold = 1; end
                7:       begin cur = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00; hold = 1; end
                default: begin cur = cur - 8'($urandom_range(1, 4)); hold = 1; end
            endcase
            if ($urandom_range(0, 15) == 0) thr = 8'($urandom);
            for (int h = 0; h < hold; h++)
                cyc(cur, thr, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
